// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the iterative MIPS multiply/divide unit.
// Pure declarations: no latency or flow control of its own.
package mips_muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int MULDIV_WIDTH  = 32;
    localparam int MULDIV_CYCLES = MULDIV_WIDTH + 1;

endpackage

// File: rtl/mips_muldiv_step.sv
// One multiply (shift-add) or restoring-divide (shift-subtract) iteration.
// Purely combinational, zero latency, no flow control.
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] aux_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] aux_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply: {acc,aux} is the product register, aux LSB is the current multiplier bit.
    // Divide: acc is the remainder, aux shifts dividend bits out and quotient bits in.
    always_comb begin
        sum     = {1'b0, acc_i} + (aux_i[0] ? {1'b0, opb_i} : '0);
        shifted = {acc_i, aux_i[WIDTH-1]};
        diff    = shifted - {1'b0, opb_i};
        if (div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                aux_o = {aux_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted[WIDTH-1:0];
                aux_o = {aux_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            aux_o = {sum[0], aux_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO registers with a 33-cycle iterative MULT/MULTU/DIV/DIVU; MTHI/MTLO in one cycle.
// start is ignored while busy; the controller must hold the instruction until busy drops.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mips_muldiv_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] aux_q, aux_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    muldiv_op_t       op_e;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] acc_s, aux_s;

    assign op_e = muldiv_op_t'(op);

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i (is_div_q),
        .acc_i (acc_q),
        .aux_i (aux_q),
        .opb_i (opb_q),
        .acc_o (acc_s),
        .aux_o (aux_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        opb_d    = opb_q;
        acc_d    = acc_q;
        aux_d    = aux_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        sgn   = (op_e == MULT) || (op_e == DIV);
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
        prod  = neg_q ? -{acc_q, aux_q} : {acc_q, aux_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_e)
                        MULT, MULTU, DIV, DIVU: begin
                            state_d  = RUN;
                            cnt_d    = CW'(WIDTH - 1);
                            is_div_d = (op_e == DIV) || (op_e == DIVU);
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            dz_d     = ((op_e == DIV) || (op_e == DIVU)) && (b == '0);
                            acc_d    = '0;
                            aux_d    = mag_a;
                            opb_d    = mag_b;
                        end
                        MTHI:    hi_d = a;
                        MTLO:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d = acc_s;
                aux_d = aux_s;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                // Divide by zero leaves |a| as remainder, so HI naturally recovers a.
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : (neg_q ? -aux_q : aux_q);
                    hi_d = rneg_q ? -acc_q : acc_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            aux_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            aux_q    <= aux_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench with an expectation queue drained by an independent done monitor.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        string        name;
    } exp_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    vec_t vecs[6] = '{
        '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{3'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF},
        '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF}
    };

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Drives start for exactly one sampling edge and records the expected result.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
        exp_t e;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        e.hi   = eh;
        e.lo   = el;
        e.cyc  = cyc + 1 + MULDIV_CYCLES;
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_hi"}, hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, lo, mon_e.lo);
                chk({mon_e.name, "_latency"}, W'(cyc), W'(mon_e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_busy", W'(busy), 0);
        chk("reset_done", W'(done), 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(MULT, 32'hFFFFFFFB, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF6, "mult_neg5x2");
        repeat (10) @(negedge clk);
        chk("run_busy", W'(busy), 1);
        chk("run_hi_hold", hi, 0);
        chk("run_lo_hold", lo, 0);
        drain();

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
            drain();
        end

        // Second op issued in the done cycle of the first.
        @(negedge clk);
        issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "b2b_first");
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", W'(done), 1);
        issue(MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, "b2b_second");
        drain();

        @(negedge clk);
        issue(MULT, 32'd6, 32'd7, 32'd0, 32'd42, "inflight_mult");
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = DIVU;
        a     = 32'd100;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("inflight_idle", W'(busy), 0);

        start = 1'b1;
        op    = MTHI;
        a     = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mthi_hi", hi, 32'hA5A5A5A5);
        chk("mthi_lo_keep", lo, 32'd42);
        chk("mthi_busy", W'(busy), 0);
        chk("mthi_done", W'(done), 0);

        @(negedge clk);
        start = 1'b1;
        op    = MTLO;
        a     = 32'h0BADF00D;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h0BADF00D);
        chk("mtlo_hi_keep", hi, 32'hA5A5A5A5);

        @(negedge clk);
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h0000FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("op6_busy", W'(busy), 0);
        chk("op6_hi", hi, 32'hA5A5A5A5);
        chk("op6_lo", lo, 32'h0BADF00D);

        @(negedge clk);
        issue(DIV, 32'd100, 32'd7, 32'd2, 32'd14, "aborted_div");
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("abort_busy", W'(busy), 0);
        chk("abort_done", W'(done), 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", W'(busy), 0);

        issue(MULT, 32'd3, 32'd4, 32'd0, 32'd12, "post_reset_mult");
        drain();
        repeat (5) @(negedge clk);
        chk("queue_empty", W'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
